signal_proc_scheduler: RTL and testbench

Round-robin scheduler that shares one filter/processing engine between `NUM_CH` sample requesters. It accepts one request at a time and latches that channel's sample and processing mode. It then issues a single-cycle start to the engine, waits for completion under a watchdog, and returns the tagged result. It sits between the per-channel sample sources and the signal-processing host's filter datapath.

---
 rtl/signal_sched_pkg.sv | 17 +
 rtl/signal_proc_scheduler_rr_arbiter.sv | 34 +++
 rtl/signal_proc_scheduler.sv | 137 +++++++++++++
 tb/tb_signal_proc_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/signal_sched_pkg.sv
// Shared types for the signal-processing scheduler: FSM state encoding and
// filter mode codes carried alongside each latched sample.
package signal_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  localparam logic [1:0] MODE_LOWPASS  = 2'd0;
  localparam logic [1:0] MODE_HIGHPASS = 2'd1;
  localparam logic [1:0] MODE_BANDPASS = 2'd2;
  localparam logic [1:0] MODE_NOTCH    = 2'd3;

endpackage

// File: rtl/signal_proc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request found searching
// upward from ptr with wrap-around wins.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         gnt,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // priority search starting at ptr, first hit wins
  always_comb begin
    gnt     = {NUM_CH{1'b0}};
    gnt_idx = {IDX_W{1'b0}};
    found_s = 1'b0;
    cand_s  = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      cand_s = IDX_W'((int'(ptr) + i) % NUM_CH);
      if (!found_s && req[cand_s]) begin
        found_s      = 1'b1;
        gnt[cand_s]  = 1'b1;
        gnt_idx      = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/signal_proc_scheduler.sv
// Shares one filter engine between NUM_CH requesters: round-robin grant,
// single-cycle engine start, watchdog-guarded wait, tagged result pulse.
module signal_proc_scheduler
  import signal_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH*DATA_W-1:0]  ch_sample,
  input  logic [NUM_CH*2-1:0]       ch_mode,
  output logic [NUM_CH-1:0]         ch_ack,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_sample,
  output logic [1:0]                eng_mode,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_result,
  output logic                      res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic                      res_err,
  output logic                      busy
);
  localparam int         IDX_W   = $clog2(NUM_CH);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  sched_state_t      state_r, state_nxt_s;
  logic [IDX_W-1:0]  grant_r, rr_ptr_r, arb_idx_s;
  logic [NUM_CH-1:0] arb_gnt_s, ch_ack_r;
  logic [7:0]        wd_cnt_r;
  logic              grant_load_s, wd_clr_s, wd_inc_s, res_load_s, ptr_load_s;
  logic              eng_start_r, res_valid_r, res_err_r, busy_r;
  logic [DATA_W-1:0] eng_sample_r, res_data_r;
  logic [1:0]        eng_mode_r;
  logic [IDX_W-1:0]  res_ch_r;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (ch_req),
    .ptr     (rr_ptr_r),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // next-state and datapath enables; done beats watchdog expiry in the same cycle
  always_comb begin
    state_nxt_s  = state_r;
    grant_load_s = 1'b0;
    wd_clr_s     = 1'b0;
    wd_inc_s     = 1'b0;
    res_load_s   = 1'b0;
    ptr_load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|ch_req) begin
          state_nxt_s  = ST_START;
          grant_load_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_WAIT;
        wd_clr_s    = 1'b1;
      end
      ST_WAIT: begin
        if (eng_done || (wd_cnt_r == WD_LAST)) begin
          state_nxt_s = ST_DONE;
          res_load_s  = 1'b1;
        end else begin
          wd_inc_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        ptr_load_s  = 1'b1;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // latches, watchdog and registered outputs, all driven by the enables above
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_ack_r     <= {NUM_CH{1'b0}};
      eng_start_r  <= 1'b0;
      eng_sample_r <= {DATA_W{1'b0}};
      eng_mode_r   <= 2'd0;
      grant_r      <= {IDX_W{1'b0}};
      rr_ptr_r     <= {IDX_W{1'b0}};
      wd_cnt_r     <= 8'd0;
      res_valid_r  <= 1'b0;
      res_data_r   <= {DATA_W{1'b0}};
      res_ch_r     <= {IDX_W{1'b0}};
      res_err_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      ch_ack_r    <= grant_load_s ? arb_gnt_s : {NUM_CH{1'b0}};
      eng_start_r <= grant_load_s;
      res_valid_r <= res_load_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (grant_load_s) begin
        grant_r      <= arb_idx_s;
        eng_sample_r <= ch_sample[arb_idx_s*DATA_W +: DATA_W];
        eng_mode_r   <= ch_mode[arb_idx_s*2 +: 2];
      end
      if (wd_clr_s)      wd_cnt_r <= 8'd0;
      else if (wd_inc_s) wd_cnt_r <= wd_cnt_r + 8'd1;
      if (res_load_s) begin
        res_data_r <= eng_done ? eng_result : {DATA_W{1'b0}};
        res_err_r  <= ~eng_done;
        res_ch_r   <= grant_r;
      end
      if (ptr_load_s)
        rr_ptr_r <= (grant_r == IDX_W'(NUM_CH - 1)) ? {IDX_W{1'b0}} : grant_r + IDX_W'(1);
    end
  end

  assign ch_ack     = ch_ack_r;
  assign eng_start  = eng_start_r;
  assign eng_sample = eng_sample_r;
  assign eng_mode   = eng_mode_r;
  assign res_valid  = res_valid_r;
  assign res_data   = res_data_r;
  assign res_ch     = res_ch_r;
  assign res_err    = res_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_signal_proc_scheduler.sv
// Directed bench for signal_proc_scheduler: vector table of single
// transactions plus hand sequences for round robin, spurious done and reset.
module tb_signal_proc_scheduler;
  import signal_sched_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*DATA_W-1:0] ch_sample;
  logic [NUM_CH*2-1:0]      ch_mode;
  logic [NUM_CH-1:0]        ch_ack;
  logic                     eng_start;
  logic [DATA_W-1:0]        eng_sample;
  logic [1:0]               eng_mode;
  logic                     eng_done;
  logic [DATA_W-1:0]        eng_result;
  logic                     res_valid;
  logic [DATA_W-1:0]        res_data;
  logic [1:0]               res_ch;
  logic                     res_err;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  signal_proc_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_sample(ch_sample), .ch_mode(ch_mode),
    .ch_ack(ch_ack), .eng_start(eng_start), .eng_sample(eng_sample), .eng_mode(eng_mode),
    .eng_done(eng_done), .eng_result(eng_result), .res_valid(res_valid),
    .res_data(res_data), .res_ch(res_ch), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int          k;          // engine answers k cycles after start; 0 = never
    logic [15:0] result;
    logic [3:0]  exp_ack;
    logic [15:0] exp_sample;
    logic [1:0]  exp_mode;
    int          exp_lat;    // res_valid cycle relative to the request cycle
    logic [15:0] exp_data;
    logic [1:0]  exp_ch;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"},   32'(ch_ack), 32'd0);
    check({tag, "_start"}, 32'(eng_start), 32'd0);
    check({tag, "_samp"},  32'(eng_sample), 32'd0);
    check({tag, "_mode"},  32'(eng_mode), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_data"},  32'(res_data), 32'd0);
    check({tag, "_ch"},    32'(res_ch), 32'd0);
    check({tag, "_err"},   32'(res_err), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  int lat;
  int cyc;
  int nack;
  logic got;
  logic pend;
  int ack_idx[5];
  int ack_cyc[5];

  initial begin
    // ch3..ch0 samples and modes
    ch_sample  = {16'h0F0F, 16'hA5A5, 16'h1111, 16'h2222};
    ch_mode    = {MODE_NOTCH, MODE_HIGHPASS, MODE_BANDPASS, MODE_LOWPASS};
    ch_req     = 4'b0000;
    eng_done   = 1'b0;
    eng_result = 16'h0000;
    rst        = 1'b1;

    vecs[0] = '{4'b0100, 3, 16'h1234, 4'b0100, 16'hA5A5, 2'd1,  5, 16'h1234, 2'd2, 1'b0};
    vecs[1] = '{4'b0010, 0, 16'hFFFF, 4'b0010, 16'h1111, 2'd2, 10, 16'h0000, 2'd1, 1'b1};
    vecs[2] = '{4'b1000, 1, 16'hBEEF, 4'b1000, 16'h0F0F, 2'd3,  3, 16'hBEEF, 2'd3, 1'b0};
    vecs[3] = '{4'b0001, 8, 16'h5A5A, 4'b0001, 16'h2222, 2'd0, 10, 16'h5A5A, 2'd0, 1'b0};
    vecs[4] = '{4'b1001, 2, 16'h0042, 4'b1000, 16'h0F0F, 2'd3,  4, 16'h0042, 2'd3, 1'b0};
    vecs[5] = '{4'b1001, 1, 16'h7777, 4'b0001, 16'h2222, 2'd0,  3, 16'h7777, 2'd0, 1'b0};
    vecs[6] = '{4'b0001, 4, 16'h0C0C, 4'b0001, 16'h2222, 2'd0,  6, 16'h0C0C, 2'd0, 1'b0};

    #2;
    check_zero("reset");
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();

    // round robin: all channels request, engine answers one cycle after start
    ch_req = 4'b1111;
    pend = 1'b0;
    nack = 0;
    cyc = 0;
    while (nack < 5 && cyc < 60) begin
      step();
      cyc++;
      eng_done = pend;
      pend = eng_start;
      eng_result = 16'h0100;
      if (ch_ack != 4'b0000) begin
        for (int i = 0; i < NUM_CH; i++) if (ch_ack[i]) ack_idx[nack] = i;
        ack_cyc[nack] = cyc;
        nack++;
      end
      if (nack == 5) ch_req = 4'b0000;
    end
    check("rr_ack_count", 32'(nack), 32'd5);
    for (int i = 0; i < nack; i++) begin
      check("rr_order", 32'(ack_idx[i]), 32'(i % NUM_CH));
      if (i > 0) check("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
    end
    while (busy && cyc < 100) begin
      step();
      cyc++;
      eng_done = pend;
      pend = eng_start;
    end
    eng_done = 1'b0;
    check("rr_drain_busy", 32'(busy), 32'd0);

    // table-driven single transactions
    for (int v = 0; v < 7; v++) begin
      ch_req = vecs[v].req;
      eng_result = vecs[v].result;
      check("idle_busy", 32'(busy), 32'd0);
      step();
      check("ack", 32'(ch_ack), 32'(vecs[v].exp_ack));
      check("eng_start", 32'(eng_start), 32'd1);
      check("eng_sample", 32'(eng_sample), 32'(vecs[v].exp_sample));
      check("eng_mode", 32'(eng_mode), 32'(vecs[v].exp_mode));
      check("start_busy", 32'(busy), 32'd1);
      ch_req = 4'b0000;
      lat = 1;
      got = 1'b0;
      while (!got && lat < 40) begin
        step();
        lat++;
        eng_done = 1'b0;
        if (lat == 2) check("start_pulse_len", 32'(eng_start | (|ch_ack)), 32'd0);
        if (res_valid) got = 1'b1;
        else if (lat - 1 == vecs[v].k) eng_done = 1'b1;
      end
      check("res_seen", 32'(got), 32'd1);
      check("res_latency", 32'(lat), 32'(vecs[v].exp_lat));
      check("res_data", 32'(res_data), 32'(vecs[v].exp_data));
      check("res_ch", 32'(res_ch), 32'(vecs[v].exp_ch));
      check("res_err", 32'(res_err), 32'(vecs[v].exp_err));
      check("sample_stable", 32'(eng_sample), 32'(vecs[v].exp_sample));
      step();
      check("back_idle_busy", 32'(busy), 32'd0);
      check("valid_pulse_len", 32'(res_valid), 32'd0);
    end

    // spurious done in IDLE
    eng_done = 1'b1;
    step();
    step();
    eng_done = 1'b0;
    check("spur_idle_busy", 32'(busy), 32'd0);
    check("spur_idle_valid", 32'(res_valid), 32'd0);
    check("spur_idle_start", 32'(eng_start), 32'd0);

    // spurious done in DONE
    ch_req = 4'b0001;
    eng_result = 16'h3C3C;
    step();
    ch_req = 4'b0000;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("spur_done_valid", 32'(res_valid), 32'd1);
    check("spur_done_data", 32'(res_data), 32'h3C3C);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("spur_after_valid", 32'(res_valid), 32'd0);
    check("spur_after_busy", 32'(busy), 32'd0);
    step();
    check("spur_after2_valid", 32'(res_valid), 32'd0);
    check("spur_after2_busy", 32'(busy), 32'd0);
    check("spur_after2_ack", 32'(ch_ack), 32'd0);

    // reset two cycles into WAIT; rr_ptr is 1 here, so without reset ch3 would win
    ch_req = 4'b0100;
    step();
    ch_req = 4'b0000;
    step();
    step();
    rst = 1'b1;
    #1;
    check_zero("midrst");
    step();
    check("midrst_hold_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ch_req = 4'b1001;
    eng_result = 16'h4321;
    step();
    check("post_rst_ack", 32'(ch_ack), 32'b0001);
    check("post_rst_sample", 32'(eng_sample), 32'h2222);
    ch_req = 4'b0000;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("post_rst_valid", 32'(res_valid), 32'd1);
    check("post_rst_ch", 32'(res_ch), 32'd0);
    check("post_rst_data", 32'(res_data), 32'h4321);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
